// File: rtl/oscu_readout_if.sv
`default_nettype none
// ============================================================================
// Module      : oscu_readout_if
// Description : Buffer-read and sample-stream signals of the OSCU readout.
// Revision    : 1.0 - initial release
// ============================================================================
interface oscu_readout_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output mem_ren, mem_raddr, out_data, out_valid, out_last,
        input  mem_rdata, out_ready
    );

    modport slave (
        input  mem_ren, mem_raddr, out_data, out_valid, out_last,
        output mem_rdata, out_ready
    );
endinterface
`default_nettype wire

// File: rtl/oscu_readout.sv
`default_nettype none
// ============================================================================
// Module      : oscu_readout
// Description : Streams the OSCU circular capture buffer out, oldest first,
//               through a 2-entry skid FIFO behind a 1-cycle-latency RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module oscu_readout #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic              abort,
    input  wire logic [ADDR_W-1:0] start_addr,
    input  wire logic [ADDR_W-1:0] last_addr,
    oscu_readout_if.master         bus,
    output logic                   busy,
    output logic                   done
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_cnt_one  = {{ADDR_W{1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_last_addr;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_issue_cnt;
    logic [ADDR_W:0]   r_send_cnt;
    logic              r_inflight;
    logic [DATA_W-1:0] r_fifo_mem [0:1];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic              r_done;

    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occ;
    logic              w_ren;
    logic              w_start;
    logic              w_finish;
    logic              w_valid;

    assign w_valid  = (r_count != 2'd0);
    assign w_pop    = w_valid && bus.out_ready;
    assign w_push   = r_inflight;
    // Entries held plus the read returning next cycle, less what leaves now.
    assign w_occ    = 3'(r_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_ren    = (r_state == S_RUN) && (r_issue_cnt != '0) && (w_occ < 3'd2);
    assign w_start  = (r_state == S_IDLE) && start && !abort;
    assign w_finish = w_pop && bus.out_last;

    assign bus.mem_ren   = w_ren;
    assign bus.mem_raddr = w_ren ? r_ptr : '0;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_valid ? r_fifo_mem[r_rptr] : '0;
    assign bus.out_last  = w_valid && (r_send_cnt == c_cnt_one);
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_state_nxt = S_RUN;
                S_RUN:   if (w_ren && r_issue_cnt == c_cnt_one) w_state_nxt = S_DRAIN;
                S_DRAIN: if (w_finish) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_last_addr <= '0;
            r_ptr       <= '0;
            r_issue_cnt <= '0;
            r_send_cnt  <= '0;
            r_inflight  <= 1'b0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= 2'd0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_finish && !abort;
            if (abort) begin
                r_inflight <= 1'b0;
                r_wptr     <= 1'b0;
                r_rptr     <= 1'b0;
                r_count    <= 2'd0;
            end else begin
                r_inflight <= w_ren;
                if (w_start) begin
                    r_last_addr <= last_addr;
                    r_ptr       <= (start_addr > last_addr) ? '0 : start_addr;
                    r_issue_cnt <= {1'b0, last_addr} + c_cnt_one;
                    r_send_cnt  <= {1'b0, last_addr} + c_cnt_one;
                end
                if (w_ren) begin
                    r_ptr       <= (r_ptr == r_last_addr) ? '0 : r_ptr + c_addr_one;
                    r_issue_cnt <= r_issue_cnt - c_cnt_one;
                end
                if (w_pop) begin
                    r_send_cnt <= r_send_cnt - c_cnt_one;
                    r_rptr     <= ~r_rptr;
                end
                if (w_push) begin
                    r_wptr <= ~r_wptr;
                end
                r_count <= r_count + 2'(w_push) - 2'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_mem[r_wptr] <= bus.mem_rdata;
        end
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(w_push && !w_pop && r_count == 2'd2));

endmodule
`default_nettype wire

// File: tb/tb_oscu_readout.sv
`default_nettype none
// ============================================================================
// Module      : tb_oscu_readout
// Description : Scoreboard bench for oscu_readout with a synchronous RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oscu_readout;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic              l;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              busy;
    logic              done;

    oscu_readout_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    oscu_readout #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .last_addr  (last_addr),
        .bus        (bus.master),
        .busy       (busy),
        .done       (done)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_pops = 0;
    int   occ = 0;
    int   max_occ = 0;
    int   addr_q [$];
    exp_t exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] sample(input int a);
        return DATA_W'((a * 37 + 11) & 255);
    endfunction

    always @(posedge clk) begin
        if (bus.mem_ren) bus.mem_rdata <= sample(int'(bus.mem_raddr));
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic fail_unexpected(input string nm, input logic [31:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h, required nothing", nm, act);
    endtask

    // Monitor: checks reads and accepted samples against the scoreboard queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (occ > max_occ) max_occ = occ;
            if (bus.mem_ren) begin
                if (addr_q.size() == 0) fail_unexpected("read_addr", 32'(bus.mem_raddr));
                else chk("read_addr", 32'(bus.mem_raddr), 32'(addr_q.pop_front()));
            end
            if (bus.out_valid && bus.out_ready) begin
                n_pops++;
                if (exp_q.size() == 0) fail_unexpected("sample", {bus.out_data, bus.out_last});
                else chk("sample_data_last", {bus.out_data, bus.out_last}, 32'(exp_q.pop_front()));
            end
            occ = occ + int'(bus.mem_ren) - int'(bus.out_valid && bus.out_ready);
        end
    end

    task automatic load_expect(input int sa, input int la);
        exp_t e;
        int   p;
        p = (sa > la) ? 0 : sa;
        for (int i = 0; i <= la; i++) begin
            addr_q.push_back(p);
            e.d = sample(p);
            e.l = (i == la);
            exp_q.push_back(e);
            p = (p == la) ? 0 : p + 1;
        end
    endtask

    task automatic run(input int sa, input int la, input int exp_done,
                       input bit rnd_ready, input int mid_cyc);
        int cyc;
        load_expect(sa, la);
        max_occ = 0;
        @(posedge clk); #1;
        start_addr = ADDR_W'(sa);
        last_addr  = ADDR_W'(la);
        start      = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        forever begin
            @(negedge clk);
            if (cyc == 1) begin
                chk("busy_cycle1", 32'(busy), 32'd1);
                chk("ren_cycle1", 32'(bus.mem_ren), 32'd1);
            end
            if (!rnd_ready && cyc == 2) chk("valid_cycle2", 32'(bus.out_valid), 32'd0);
            if (!rnd_ready && cyc == 3) chk("valid_cycle3", 32'(bus.out_valid), 32'd1);
            if (done) begin
                if (exp_done > 0) chk("done_cycle", 32'(cyc), 32'(exp_done));
                chk("busy_at_done", 32'(busy), 32'd0);
                break;
            end
            if (cyc > 2000) begin
                fail_unexpected("timeout_waiting_done", 32'(cyc));
                break;
            end
            @(posedge clk); #1;
            cyc++;
            if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
            if (mid_cyc > 0 && cyc == mid_cyc) begin
                start      = 1'b1;
                start_addr = 7'd1;
                last_addr  = 7'd3;
            end
            if (mid_cyc > 0 && cyc == mid_cyc + 1) start = 1'b0;
        end
        chk("reads_outstanding", 32'(addr_q.size()), 32'd0);
        chk("samples_outstanding", 32'(exp_q.size()), 32'd0);
        bus.out_ready = 1'b1;
    endtask

    task automatic abort_test();
        int dseen;
        load_expect(2, 9);
        n_pops = 0;
        @(posedge clk); #1;
        start_addr = 7'd2;
        last_addr  = 7'd9;
        start      = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        abort = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        bus.out_ready = 1'b1;
        addr_q.delete();
        exp_q.delete();
        occ = 0;
        @(negedge clk);
        chk("abort_pops", 32'(n_pops), 32'd3);
        chk("abort_busy_valid_ren", {busy, bus.out_valid, bus.mem_ren}, 32'd0);
        dseen = int'(done);
        repeat (5) begin
            @(negedge clk);
            dseen += int'(done);
        end
        chk("abort_no_done", 32'(dseen), 32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b1;
        abort         = 1'b0;
        start_addr    = 7'd4;
        last_addr     = 7'd9;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_outputs",
                {bus.mem_ren, bus.mem_raddr, bus.out_data, bus.out_valid, bus.out_last, busy, done},
                32'd0);
        end
        #1;
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_reset", 32'(busy), 32'd0);

        run(4, 9, 13, 1'b0, 0);
        run(100, 127, -1, 1'b1, 0);
        chk("max_fifo_occupancy_le2", 32'(max_occ <= 2), 32'd1);
        abort_test();
        run(7, 9, 13, 1'b0, 0);
        run(0, 0, 4, 1'b0, 0);
        run(12, 5, 9, 1'b0, 4);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/oscu_readout.md
# oscu_readout

Readout engine for the OSCU capture buffer. The OSCU address counter writes samples into a circular buffer. This block reads that buffer back, starting at the oldest sample and wrapping at the same rollover address, and streams the samples out over a valid/ready interface. It issues pipelined reads into the synchronous buffer RAM, which has one cycle of read latency, and holds data in a 2-entry skid FIFO so backpressure never drops or duplicates a sample.

## Interface
- ADDR_W, 7: buffer address width, matching the 7-bit OSCU address counter.
- DATA_W, 8: sample width.
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a readout; honoured only in IDLE.
- abort  in  1  cancels a readout in any state.
- start_addr  in  ADDR_W  address of the oldest sample, i.e. the OSCU write pointer at the end of capture.
- last_addr  in  ADDR_W  rollover address, the same value the OSCU counter rolls over at.
- mem_ren  out  1  buffer read enable.
- mem_raddr  out  ADDR_W  buffer read address.
- mem_rdata  in  DATA_W  buffer read data, valid the cycle after mem_ren.
- out_data  out  DATA_W  streamed sample.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  the consumer accepts the sample.
- out_last  out  1  marks the final sample of the readout; qualified by out_valid.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse when a readout completes normally.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: issuing reads; draining returned data.
  - DRAIN: all reads issued; waiting for the FIFO to empty.
- IDLE to RUN on start && !abort:
  - Latch last_addr.
  - Set ptr = start_addr. If start_addr > last_addr, set ptr = 0 instead.
  - Set the issue and send counters (ADDR_W+1 bits) to last_addr+1, the total sample count; range 1..2^ADDR_W.
- Read issue:
  - mem_ren is asserted when issue_cnt != 0 and (fifo_count + inflight − pop) < 2.
  - pop = out_valid && out_ready.
  - inflight = mem_ren registered by one cycle.
- On each issue:
  - mem_raddr = ptr.
  - ptr becomes 0 if ptr == last_addr, else ptr+1.
  - issue_cnt decrements.
- Data path:
  - mem_rdata is pushed into the FIFO on the cycle after mem_ren.
  - out_data and out_valid come from the FIFO head.
  - Push and pop in the same cycle are legal.
  - The FIFO never overflows. Overflow is an assertion failure.
- Ending a readout:
  - out_last = out_valid && send_cnt == 1.
  - send_cnt decrements on each pop.
  - RUN to DRAIN when issue_cnt reaches 0.
  - DRAIN to IDLE on the pop with out_last set.
  - done pulses in the cycle after that pop.
- Abort:
  - Any state goes to IDLE on the next edge.
  - The FIFO is flushed and in-flight read data is discarded.
  - No done pulse is generated.
  - abort has priority over start.
- start outside IDLE is ignored.
- Input changes while busy are ignored, since start_addr and last_addr are latched at start.

## Timing
- Reset values, held while rst is high:
  - mem_ren, mem_raddr, out_data, out_valid, out_last, busy, done = 0.
  - FIFO empty; state IDLE.
- Startup (start sampled at edge 0):
  - busy = 1 from cycle 1.
  - First mem_ren in cycle 1.
  - First out_valid in cycle 3.
- With out_ready held high: one sample per cycle sustained, with no bubbles after the first.
- For N samples and no backpressure:
  - Last pop in cycle N+2.
  - done = 1 and busy = 0 in cycle N+3.
- Abort sampled at edge k: out_valid = 0, mem_ren = 0 and busy = 0 from cycle k+1.
- A new start is accepted in the same cycle done pulses, because the state is already IDLE.

## Test plan
- Reset:
  - Stimulus: assert rst for 3 cycles with start = 1.
  - Required: all outputs stay 0 and busy = 0 after rst drops.
- Wrap-around readout:
  - Stimulus: last_addr = 9, start_addr = 4, out_ready = 1.
  - Required: mem_raddr sequence is 4,5,6,7,8,9,0,1,2,3.
  - Required: 10 samples in order, out_last only on the 10th, done in cycle 13.
- Backpressure:
  - Stimulus: last_addr = 127, start_addr = 100, out_ready toggled pseudo-randomly.
  - Required: all 128 samples delivered exactly once, in address order 100..127, 0..99.
  - Required: the FIFO never exceeds 2 entries.
- Abort:
  - Stimulus: assert abort after 3 accepted samples of a 10-sample readout.
  - Required: next cycle busy = 0 and out_valid = 0, and no done pulse.
  - Required: a following start reads from the new start_addr cleanly.
- Single sample:
  - Stimulus: last_addr = 0.
  - Required: one read at address 0, with out_valid and out_last high together, then done.
- Illegal start conditions:
  - Stimulus: start_addr = 12 with last_addr = 5.
  - Required: readout starts at address 0.
  - Stimulus: pulse start mid-run.
  - Required: no effect on the sequence or the counts.
